cache_req_port: RTL and testbench

CACHE_REQ_PORT -- requirements
Module: cache_req_port

---
 rtl/cache_req_pkg.sv | 19 +
 rtl/req_fifo.sv | 74 +++++++
 rtl/cache_req_port.sv | 173 +++++++++++++++++
 tb/tb_cache_req_port.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_req_pkg.sv
// Shared types for the cache request port: FSM state encoding and request payload.
package cache_req_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/req_fifo.sv
// Request FIFO: power-of-two depth, pointers wrap naturally, push ignored when full.
module req_fifo
  import cache_req_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  req_t                     push_data,
  input  logic                     pop,
  output req_t                     pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  req_t             mem_q [DEPTH];
  req_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == OCC_W'(DEPTH));
  assign empty    = (count_q == OCC_W'(0));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  // Next pointer, occupancy and storage contents.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read behind a valid write.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cache_req_port.sv
// Queues producer requests and issues them one at a time to a cache, with hit/miss/stall stats.
module cache_req_port
  import cache_req_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_miss,
  output logic              cache_rd_req,
  output logic              cache_wr_req,
  output logic [31:0]       cache_addr,
  output logic [31:0]       cache_wr_data,
  input  logic              cache_miss,
  input  logic [31:0]       cache_rd_data,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e                      state_q, state_d;
  req_t                        req_q, req_d;
  logic                        miss_q, miss_d;
  logic                        first_q, first_d;
  logic [CNT_W-1:0]            hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]            miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;

  req_t                        push_req;
  req_t                        fifo_head;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Pack the producer fields into the queued request payload.
  always_comb begin
    push_req       = '0;
    push_req.we    = req_we;
    push_req.addr  = req_addr;
    push_req.wdata = req_wdata;
  end

  req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid),
    .push_data (push_req),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign req_ready = ~fifo_full;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: one request in flight, completion when the cache reports no miss.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: if (!cache_miss) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request capture, first-cycle miss sampling and saturating statistics.
  always_comb begin
    fifo_pop    = 1'b0;
    req_d       = req_q;
    miss_d      = miss_q;
    first_d     = first_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_IDLE && !fifo_empty) begin
      fifo_pop = 1'b1;
      req_d    = fifo_head;
      miss_d   = 1'b0;
      first_d  = 1'b1;
    end
    if (state_q == ST_ISSUE) begin
      if (first_q) begin
        miss_d  = cache_miss;
        first_d = 1'b0;
      end
      // miss_q is cleared on entry, so a first-cycle hit reads it as 0.
      if (cache_miss) begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end else if (miss_q) begin
        miss_cnt_d = sat_inc(miss_cnt_q);
      end else begin
        hit_cnt_d = sat_inc(hit_cnt_q);
      end
    end
  end

  // Datapath and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q       <= '0;
      miss_q      <= 1'b0;
      first_q     <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      req_q       <= req_d;
      miss_q      <= miss_d;
      first_q     <= first_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // FSM outputs: cache strobes only in ISSUE, response only in RESP.
  always_comb begin
    cache_rd_req  = 1'b0;
    cache_wr_req  = 1'b0;
    cache_addr    = '0;
    cache_wr_data = '0;
    resp_valid    = 1'b0;
    resp_miss     = 1'b0;
    resp_rdata    = '0;
    case (state_q)
      ST_ISSUE: begin
        cache_rd_req  = ~req_q.we;
        cache_wr_req  = req_q.we;
        cache_addr    = req_q.addr;
        cache_wr_data = req_q.wdata;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_miss  = miss_q;
        resp_rdata = req_q.we ? '0 : cache_rd_data;
      end
      default: begin
      end
    endcase
  end

  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_cache_req_port.sv
// Directed bench for cache_req_port: default-width instance plus a 4-bit-counter instance.
module tb_cache_req_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        cache_miss;
  logic [31:0] cache_rd_data;

  logic        req_ready, resp_valid, resp_miss, cache_rd_req, cache_wr_req;
  logic [31:0] resp_rdata, cache_addr, cache_wr_data;
  logic [31:0] hit_cnt, miss_cnt, stall_cnt;

  logic        s_req_ready, s_resp_valid, s_resp_miss, s_cache_rd_req, s_cache_wr_req;
  logic [31:0] s_resp_rdata, s_cache_addr, s_cache_wr_data;
  logic [3:0]  s_hit_cnt, s_miss_cnt, s_stall_cnt;

  logic        use_model, drv_miss, model_miss;
  logic [31:0] drv_rdata, model_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign cache_miss    = use_model ? model_miss  : drv_miss;
  assign cache_rd_data = use_model ? model_rdata : drv_rdata;

  cache_req_port dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_miss(resp_miss), .cache_rd_req(cache_rd_req), .cache_wr_req(cache_wr_req),
    .cache_addr(cache_addr), .cache_wr_data(cache_wr_data), .cache_miss(cache_miss),
    .cache_rd_data(cache_rd_data), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .stall_cnt(stall_cnt)
  );

  cache_req_port #(.FIFO_DEPTH(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata),
    .resp_miss(s_resp_miss), .cache_rd_req(s_cache_rd_req), .cache_wr_req(s_cache_wr_req),
    .cache_addr(s_cache_addr), .cache_wr_data(s_cache_wr_data), .cache_miss(cache_miss),
    .cache_rd_data(cache_rd_data), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt), .stall_cnt(s_stall_cnt)
  );

  // Cache model: 16-line direct-mapped tag store, two miss cycles per fill, word backing store.
  logic        tag_v [16];
  logic [23:0] tag_a [16];
  logic [31:0] mem   [4096];
  logic [1:0]  fill_cnt;
  logic [3:0]  m_idx;
  logic [11:0] m_word;
  logic        m_act;

  assign m_idx      = cache_addr[7:4];
  assign m_word     = cache_addr[13:2];
  assign m_act      = use_model & (cache_rd_req | cache_wr_req);
  assign model_miss = m_act & ~(tag_v[m_idx] & (tag_a[m_idx] == cache_addr[31:8]));

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) tag_v[i] <= 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      fill_cnt    <= 2'd0;
      model_rdata <= 32'd0;
    end else if (m_act) begin
      if (model_miss) begin
        if (fill_cnt == 2'd1) begin
          tag_v[m_idx] <= 1'b1;
          tag_a[m_idx] <= cache_addr[31:8];
          fill_cnt     <= 2'd0;
        end else begin
          fill_cnt <= fill_cnt + 2'd1;
        end
      end else if (cache_wr_req) begin
        mem[m_word] <= cache_wr_data;
      end else begin
        model_rdata <= mem[m_word];
      end
    end
  end

  // Strobes must never both be high.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      total++;
      if ((cache_rd_req & cache_wr_req) !== 1'b0) begin
        bad++;
        $display("FAIL strobe_exclusive rd=%0b wr=%0b exp not both 1", cache_rd_req, cache_wr_req);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    drv_miss = 1'b0; drv_rdata = '0; use_model = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", req_ready); end
    total++; if ({resp_valid, resp_miss, cache_rd_req, cache_wr_req} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {resp_valid, resp_miss, cache_rd_req, cache_wr_req}); end
    total++; if ({resp_rdata, cache_addr, cache_wr_data} !== 96'd0) begin
      bad++; $display("FAIL reset_buses rdata=%h addr=%h wdata=%h exp=0", resp_rdata, cache_addr, cache_wr_data); end
    total++; if ({hit_cnt, miss_cnt, stall_cnt} !== 96'd0) begin
      bad++; $display("FAIL reset_counters hit=%0d miss=%0d stall=%0d exp=0", hit_cnt, miss_cnt, stall_cnt); end
  endtask

  task automatic test_hit_read;
    do_reset;
    drv_rdata = 32'h1234_5678;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040; req_wdata = 32'h0;
    tick;
    req_valid = 1'b0;
    total++; if (cache_rd_req !== 1'b0) begin bad++; $display("FAIL hit_cycleN_idle rd_req=%0b exp=0", cache_rd_req); end
    tick;
    total++; if ({cache_rd_req, cache_wr_req} !== 2'b10) begin
      bad++; $display("FAIL hit_issue_strobes got=%b exp=10", {cache_rd_req, cache_wr_req}); end
    total++; if (cache_addr !== 32'h0000_0040) begin bad++; $display("FAIL hit_issue_addr got=%h exp=00000040", cache_addr); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL hit_issue_no_resp got=%0b exp=0", resp_valid); end
    tick;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL hit_resp_valid got=%0b exp=1", resp_valid); end
    total++; if (resp_rdata !== 32'h1234_5678) begin bad++; $display("FAIL hit_resp_rdata got=%h exp=12345678", resp_rdata); end
    total++; if (resp_miss !== 1'b0) begin bad++; $display("FAIL hit_resp_miss got=%0b exp=0", resp_miss); end
    total++; if (hit_cnt !== 32'd1 || miss_cnt !== 32'd0) begin
      bad++; $display("FAIL hit_counts hit=%0d miss=%0d exp=1/0", hit_cnt, miss_cnt); end
    tick;
    total++; if ({resp_valid, cache_rd_req, resp_rdata} !== 34'd0) begin
      bad++; $display("FAIL hit_after valid=%0b rd=%0b rdata=%h exp=0", resp_valid, cache_rd_req, resp_rdata); end
  endtask

  task automatic test_miss_write;
    int wr_cycles;
    logic stable;
    do_reset;
    drv_miss = 1'b1; drv_rdata = 32'hFFFF_FFFF;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0100; req_wdata = 32'hDEAD_BEEF;
    tick;
    req_valid = 1'b0; req_we = 1'b0;
    tick;
    wr_cycles = 0; stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (cache_wr_req === 1'b1) wr_cycles++;
      if (cache_addr !== 32'h100 || cache_wr_data !== 32'hDEAD_BEEF || cache_rd_req !== 1'b0 || resp_valid !== 1'b0)
        stable = 1'b0;
      if (i == 5) drv_miss = 1'b0;
      tick;
    end
    total++; if (wr_cycles != 6) begin bad++; $display("FAIL miss_wr_hold got=%0d exp=6", wr_cycles); end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL miss_wr_stable got=%0b exp=1", stable); end
    total++; if ({resp_valid, resp_miss} !== 2'b11) begin
      bad++; $display("FAIL miss_resp valid/miss got=%b exp=11", {resp_valid, resp_miss}); end
    total++; if (resp_rdata !== 32'd0) begin bad++; $display("FAIL miss_resp_rdata got=%h exp=0", resp_rdata); end
    total++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
      bad++; $display("FAIL miss_counts miss=%0d hit=%0d exp=1/0", miss_cnt, hit_cnt); end
    total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL miss_stall got=%0d exp=5", stall_cnt); end
    tick;
    total++; if ({resp_valid, cache_wr_req, cache_addr} !== 34'd0) begin
      bad++; $display("FAIL miss_after valid=%0b wr=%0b addr=%h exp=0", resp_valid, cache_wr_req, cache_addr); end
  endtask

  task automatic test_back_pressure;
    int n;
    logic [31:0] last_addr;
    do_reset;
    drv_miss = 1'b1; drv_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1000 + 32'(i * 4);
      total++; if (req_ready !== (i < 5)) begin
        bad++; $display("FAIL bp_ready_%0d got=%0b exp=%0b", i, req_ready, (i < 5)); end
      tick;
    end
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%0b exp=0", req_ready); end
    total++; if (cache_rd_req !== 1'b1 || cache_addr !== 32'h1000) begin
      bad++; $display("FAIL bp_in_issue rd=%0b addr=%h exp=1/00001000", cache_rd_req, cache_addr); end
    drv_miss = 1'b0;
    n = 0; last_addr = '0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      if (cache_rd_req === 1'b1) last_addr = cache_addr;
      if (resp_valid === 1'b1) begin
        total++; if (last_addr !== 32'h1000 + 32'(n * 4)) begin
          bad++; $display("FAIL bp_order_%0d got=%h exp=%h", n, last_addr, 32'h1000 + 32'(n * 4)); end
        total++; if (resp_miss !== (n == 0)) begin
          bad++; $display("FAIL bp_miss_%0d got=%0b exp=%0b", n, resp_miss, (n == 0)); end
        n++;
      end
      tick;
    end
    total++; if (n != 5) begin bad++; $display("FAIL bp_resp_count got=%0d exp=5", n); end
    total++; if (hit_cnt !== 32'd4 || miss_cnt !== 32'd1 || stall_cnt !== 32'd4) begin
      bad++; $display("FAIL bp_counts hit=%0d miss=%0d stall=%0d exp=4/1/4", hit_cnt, miss_cnt, stall_cnt); end
  endtask

  task automatic test_reset_mid;
    int seen;
    do_reset;
    drv_rdata = 32'h0000_0001;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h200;
    tick;
    req_valid = 1'b0;
    tick; tick; tick;
    total++; if (hit_cnt !== 32'd1) begin bad++; $display("FAIL rmid_pre_hit got=%0d exp=1", hit_cnt); end
    drv_miss = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 32'h300 + 32'(i * 4);
      tick;
    end
    req_valid = 1'b0;
    total++; if (cache_rd_req !== 1'b1 || cache_addr !== 32'h300) begin
      bad++; $display("FAIL rmid_in_issue rd=%0b addr=%h exp=1/00000300", cache_rd_req, cache_addr); end
    rst = 1'b1;
    tick;
    total++; if ({cache_rd_req, cache_wr_req, resp_valid} !== 3'b000 || cache_addr !== 32'd0) begin
      bad++; $display("FAIL rmid_strobes rd=%0b wr=%0b valid=%0b addr=%h exp=0", cache_rd_req, cache_wr_req, resp_valid, cache_addr); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%0b exp=1", req_ready); end
    total++; if ({hit_cnt, miss_cnt, stall_cnt} !== 96'd0) begin
      bad++; $display("FAIL rmid_counters hit=%0d miss=%0d stall=%0d exp=0", hit_cnt, miss_cnt, stall_cnt); end
    rst = 1'b0; drv_miss = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if ((resp_valid | cache_rd_req | cache_wr_req) === 1'b1) seen++;
      tick;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rmid_abandoned activity_cycles=%0d exp=0", seen); end
  endtask

  task automatic test_saturation;
    int acc, nresp;
    do_reset;
    drv_rdata = 32'h0000_00AB;
    acc = 0; nresp = 0;
    for (int c = 0; c < 200 && nresp < 17; c++) begin
      if (resp_valid === 1'b1) nresp++;
      if (acc < 17) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h400 + 32'(acc * 4);
        if (req_ready === 1'b1) acc++;
      end else begin
        req_valid = 1'b0;
      end
      tick;
    end
    req_valid = 1'b0;
    total++; if (nresp != 17) begin bad++; $display("FAIL sat_resp_count got=%0d exp=17", nresp); end
    total++; if (s_hit_cnt !== 4'd15) begin bad++; $display("FAIL sat_hit_cnt4 got=%0d exp=15", s_hit_cnt); end
    total++; if (hit_cnt !== 32'd17) begin bad++; $display("FAIL sat_hit_cnt32 got=%0d exp=17", hit_cnt); end
    total++; if (s_miss_cnt !== 4'd0) begin bad++; $display("FAIL sat_miss_cnt4 got=%0d exp=0", s_miss_cnt); end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic got, output logic [31:0] rd, output logic ms);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    tick;
    req_valid = 1'b0; req_we = 1'b0;
    got = 1'b0; rd = '0; ms = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      if (resp_valid === 1'b1) begin
        got = 1'b1; rd = resp_rdata; ms = resp_miss;
      end else begin
        tick;
      end
    end
  endtask

  task automatic test_mixed;
    logic got, ms;
    logic [31:0] rd;
    do_reset;
    use_model = 1'b1;
    do_req(1'b1, 32'h0000_0020, 32'd7, got, rd, ms);
    total++; if (got !== 1'b1 || ms !== 1'b1 || rd !== 32'd0) begin
      bad++; $display("FAIL mix_wr got=%0b miss=%0b rdata=%h exp=1/1/0", got, ms, rd); end
    do_req(1'b0, 32'h0000_0020, 32'd0, got, rd, ms);
    total++; if (got !== 1'b1 || ms !== 1'b0 || rd !== 32'd7) begin
      bad++; $display("FAIL mix_rd20 got=%0b miss=%0b rdata=%h exp=1/0/7", got, ms, rd); end
    do_req(1'b0, 32'h0000_2020, 32'd0, got, rd, ms);
    total++; if (got !== 1'b1 || ms !== 1'b1 || rd !== 32'hA000_0808) begin
      bad++; $display("FAIL mix_rd2020 got=%0b miss=%0b rdata=%h exp=1/1/a0000808", got, ms, rd); end
    total++; if (hit_cnt !== 32'd1 || miss_cnt !== 32'd2 || stall_cnt !== 32'd4) begin
      bad++; $display("FAIL mix_counts hit=%0d miss=%0d stall=%0d exp=1/2/4", hit_cnt, miss_cnt, stall_cnt); end
    tick;
    use_model = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    drv_miss = 1'b0; drv_rdata = '0; use_model = 1'b0;
    test_reset;
    test_hit_read;
    test_miss_write;
    test_back_pressure;
    test_reset_mid;
    test_saturation;
    test_mixed;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
